// File: rtl/waveform_bitmap_writer.sv
// Sets single pixels in a bitmap memory by read-modify-write and clears the whole frame on request.
// Optional macro WAVEFORM_DROP_COUNT_EN enables the saturating dropped_count counter; otherwise it is tied to 0.
module waveform_bitmap_writer #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_LENGTH = 14,
  parameter int DEPTH          = 13824
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDRESS_LENGTH-1:0] word_address,
  input  logic [4:0]                bit_offset,
  input  logic                      word_and_offset_valid,
  input  logic                      frame_clear,
  output logic [ADDRESS_LENGTH-1:0] mem_addr,
  output logic                      mem_rd_en,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  output logic                      mem_wr_en,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic                      busy,
  output logic                      clear_done,
  output logic [15:0]               dropped_count
);

  localparam logic [ADDRESS_LENGTH:0]   LP_DEPTH = (ADDRESS_LENGTH+1)'(DEPTH);
  localparam logic [ADDRESS_LENGTH-1:0] LP_LAST  = ADDRESS_LENGTH'(DEPTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_WRITE, S_CLEAR} state_t;

  state_t                    r_state;
  state_t                    w_next_state;
  logic                      r_hold_vld;
  logic [ADDRESS_LENGTH-1:0] r_hold_addr;
  logic [4:0]                r_hold_off;
  logic [ADDRESS_LENGTH-1:0] r_work_addr;
  logic [4:0]                r_work_off;
  logic [DATA_WIDTH-1:0]     r_rdata;
  logic                      r_clear_pending;
  logic [ADDRESS_LENGTH-1:0] r_clear_addr;
  logic                      r_clear_done;

  logic                      w_in_range;
  logic                      w_move;
  logic                      w_accept;
  logic                      w_clear_start;
  logic                      w_clear_last;
  logic [DATA_WIDTH-1:0]     w_bit_mask;

  // The hold slot counts as free in the same cycle its entry moves to the work registers.
  assign w_in_range    = {1'b0, word_address} < LP_DEPTH;
  assign w_clear_start = (r_state == S_IDLE) && r_clear_pending;
  assign w_move        = (r_state == S_IDLE) && !r_clear_pending && r_hold_vld;
  assign w_accept      = word_and_offset_valid && w_in_range && (!r_hold_vld || w_move);
  assign w_clear_last  = (r_state == S_CLEAR) && (r_clear_addr == LP_LAST);
  assign w_bit_mask    = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << r_work_off;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (r_clear_pending) begin
          w_next_state = S_CLEAR;
        end else if (r_hold_vld) begin
          w_next_state = S_READ;
        end
      end
      S_READ:  w_next_state = S_WAIT;
      S_WAIT:  w_next_state = S_WRITE;
      S_WRITE: w_next_state = S_IDLE;
      S_CLEAR: begin
        if (w_clear_last) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    mem_addr  = '0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_wdata = '0;
    unique case (r_state)
      S_READ: begin
        mem_addr  = r_work_addr;
        mem_rd_en = 1'b1;
      end
      S_WRITE: begin
        mem_addr  = r_work_addr;
        mem_wr_en = 1'b1;
        mem_wdata = r_rdata | w_bit_mask;
      end
      S_CLEAR: begin
        mem_addr  = r_clear_addr;
        mem_wr_en = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold_vld  <= 1'b0;
      r_hold_addr <= '0;
      r_hold_off  <= '0;
      r_work_addr <= '0;
      r_work_off  <= '0;
      r_rdata     <= '0;
    end else begin
      if (w_accept) begin
        r_hold_vld  <= 1'b1;
        r_hold_addr <= word_address;
        r_hold_off  <= bit_offset;
      end else if (w_move) begin
        r_hold_vld <= 1'b0;
      end
      if (w_move) begin
        r_work_addr <= r_hold_addr;
        r_work_off  <= r_hold_off;
      end
      if (r_state == S_WAIT) begin
        r_rdata <= mem_rdata;
      end
    end
  end

  // A clear request is ignored while one is already queued or running.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clear_pending <= 1'b0;
      r_clear_addr    <= '0;
      r_clear_done    <= 1'b0;
    end else begin
      if (w_clear_start) begin
        r_clear_pending <= 1'b0;
      end else if (frame_clear && (r_state != S_CLEAR)) begin
        r_clear_pending <= 1'b1;
      end
      if (w_clear_start) begin
        r_clear_addr <= '0;
      end else if (r_state == S_CLEAR) begin
        r_clear_addr <= r_clear_addr + 1'b1;
      end
      r_clear_done <= w_clear_last;
    end
  end

  assign busy       = (r_state != S_IDLE) || r_hold_vld;
  assign clear_done = r_clear_done;

`ifdef WAVEFORM_DROP_COUNT_EN
  logic [15:0] r_dropped_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dropped_count <= '0;
    end else if (word_and_offset_valid && !w_accept && (r_dropped_count != 16'hFFFF)) begin
      r_dropped_count <= r_dropped_count + 16'd1;
    end
  end

  assign dropped_count = r_dropped_count;
`else
  assign dropped_count = 16'h0000;
`endif

endmodule

// File: tb/tb_waveform_bitmap_writer.sv
// Directed bench for waveform_bitmap_writer with a behavioural bitmap memory; honours WAVEFORM_DROP_COUNT_EN.
module tb_waveform_bitmap_writer;

  localparam int DEPTH = 13824;
`ifdef WAVEFORM_DROP_COUNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [13:0] word_address;
  logic [4:0]  bit_offset;
  logic        word_and_offset_valid;
  logic        frame_clear;
  logic [13:0] mem_addr;
  logic        mem_rd_en;
  logic [31:0] mem_rdata;
  logic        mem_wr_en;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        clear_done;
  logic [15:0] dropped_count;

  waveform_bitmap_writer dut (
    .clk                   (clk),
    .reset                 (reset),
    .word_address          (word_address),
    .bit_offset            (bit_offset),
    .word_and_offset_valid (word_and_offset_valid),
    .frame_clear           (frame_clear),
    .mem_addr              (mem_addr),
    .mem_rd_en             (mem_rd_en),
    .mem_rdata             (mem_rdata),
    .mem_wr_en             (mem_wr_en),
    .mem_wdata             (mem_wdata),
    .busy                  (busy),
    .clear_done            (clear_done),
    .dropped_count         (dropped_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pat(int i);
    return 32'hC0DE0000 ^ 32'(i);
  endfunction

  // Memory model: one-cycle read latency, plus a bulk preload port for the bench.
  logic [31:0] mem [0:DEPTH-1];
  logic        fill_req;
  int          fill_lo, fill_hi;
  logic [31:0] fill_val;
  logic        fill_pat;
  int          rd_cnt, wr_cnt, zero_wr_cnt, done_cnt, both_cnt;

  initial begin
    fill_req = 1'b0; fill_lo = 0; fill_hi = 0; fill_val = '0; fill_pat = 1'b0;
    rd_cnt = 0; wr_cnt = 0; zero_wr_cnt = 0; done_cnt = 0; both_cnt = 0;
    mem_rdata = '0;
  end

  always @(posedge clk) begin
    if (fill_req) begin
      for (int i = fill_lo; i <= fill_hi; i++) mem[i] <= fill_pat ? pat(i) : fill_val;
    end else if (mem_wr_en) begin
      mem[mem_addr] <= mem_wdata;
    end
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
    if (!reset) begin
      if (mem_rd_en) rd_cnt <= rd_cnt + 1;
      if (mem_wr_en) wr_cnt <= wr_cnt + 1;
      if (mem_wr_en && mem_wdata == 32'h0) zero_wr_cnt <= zero_wr_cnt + 1;
      if (clear_done) done_cnt <= done_cnt + 1;
      if (mem_rd_en && mem_wr_en) both_cnt <= both_cnt + 1;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic fill(input int lo, input int hi, input logic [31:0] val, input logic use_pat);
    fill_lo = lo; fill_hi = hi; fill_val = val; fill_pat = use_pat; fill_req = 1'b1;
    @(negedge clk);
    fill_req = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic strobe(input logic [13:0] a, input logic [4:0] o);
    word_address = a; bit_offset = o; word_and_offset_valid = 1'b1;
    @(negedge clk);
    word_and_offset_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'b0, busy}, 32'h0);
  endtask

  typedef struct {
    logic [13:0] addr;
    logic [4:0]  off;
    logic [31:0] init;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int rd0, wr0, zw0, dn0, bad;
    logic [31:0] r_rd, r_wr, r_wd, r_ad;

    vecs[0] = '{14'd5,     5'd31, 32'h00000001, 32'h80000001};
    vecs[1] = '{14'd0,     5'd0,  32'h00000000, 32'h00000001};
    vecs[2] = '{14'd13823, 5'd15, 32'hFFFF0000, 32'hFFFF8000};
    vecs[3] = '{14'd100,   5'd4,  32'h00000010, 32'h00000010};
    vecs[4] = '{14'd42,    5'd6,  32'hA5A5A5A5, 32'hA5A5A5E5};
    vecs[5] = '{14'd8191,  5'd1,  32'hFFFFFFFC, 32'hFFFFFFFE};

    reset = 1'b1; word_address = '0; bit_offset = '0;
    word_and_offset_valid = 1'b0; frame_clear = 1'b0;
    repeat (2) @(negedge clk);
    check("reset rd_en",   {31'b0, mem_rd_en},  32'h0);
    check("reset wr_en",   {31'b0, mem_wr_en},  32'h0);
    check("reset busy",    {31'b0, busy},       32'h0);
    check("reset done",    {31'b0, clear_done}, 32'h0);
    check("reset dropped", {16'b0, dropped_count}, 32'h0);
    check("reset addr",    {18'b0, mem_addr},   32'h0);
    check("reset wdata",   mem_wdata,           32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Cycle-exact single plot: read one cycle after accept, write three cycles after.
    fill(5, 5, 32'h00000001, 1'b0);
    rd0 = rd_cnt;
    strobe(14'd5, 5'd31);
    check("accept busy", {31'b0, busy}, 32'h1);
    r_rd = '0; r_wr = '0; r_wd = '0; r_ad = '0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      r_rd[k] = mem_rd_en;
      r_wr[k] = mem_wr_en;
      if (k == 1) r_ad = {18'b0, mem_addr};
      if (k == 3) r_wd = mem_wdata;
    end
    check("timing rd_en", r_rd, 32'h00000002);
    check("timing wr_en", r_wr, 32'h00000008);
    check("timing rd addr", r_ad, 32'd5);
    check("timing wdata", r_wd, 32'h80000001);
    check("timing mem5", mem[5], 32'h80000001);
    check("timing rd count", rd_cnt - rd0, 1);

    for (int v = 0; v < 6; v++) begin
      fill(vecs[v].addr, vecs[v].addr, vecs[v].init, 1'b0);
      rd0 = rd_cnt; wr0 = wr_cnt;
      strobe(vecs[v].addr, vecs[v].off);
      wait_idle($sformatf("vec%0d timeout", v), 20);
      check($sformatf("vec%0d word", v), mem[vecs[v].addr], vecs[v].exp);
      check($sformatf("vec%0d reads", v), rd_cnt - rd0, 1);
      check($sformatf("vec%0d writes", v), wr_cnt - wr0, 1);
    end

    // Back-to-back strobes: second accepted as the first leaves hold, third dropped.
    do_reset();
    fill(1, 3, 32'h0, 1'b0);
    rd0 = rd_cnt;
    word_and_offset_valid = 1'b1;
    word_address = 14'd1; bit_offset = 5'd3; @(negedge clk);
    word_address = 14'd2; bit_offset = 5'd4; @(negedge clk);
    word_address = 14'd3; bit_offset = 5'd5; @(negedge clk);
    word_and_offset_valid = 1'b0;
    wait_idle("b2b timeout", 30);
    check("b2b word1", mem[1], 32'h00000008);
    check("b2b word2", mem[2], 32'h00000010);
    check("b2b word3", mem[3], 32'h00000000);
    check("b2b reads", rd_cnt - rd0, 2);
    check("b2b dropped", {16'b0, dropped_count}, DROP_EN ? 32'd1 : 32'd0);

    // Out-of-range address: no memory traffic.
    do_reset();
    rd0 = rd_cnt; wr0 = wr_cnt;
    strobe(14'd13824, 5'd0);
    repeat (5) @(negedge clk);
    check("oor busy", {31'b0, busy}, 32'h0);
    check("oor accesses", (rd_cnt - rd0) + (wr_cnt - wr0), 0);
    check("oor dropped", {16'b0, dropped_count}, DROP_EN ? 32'd1 : 32'd0);

    // Simultaneous clear and plot: clear first, then plot into the cleared frame.
    do_reset();
    fill(0, DEPTH-1, 32'hFFFFFFFF, 1'b0);
    rd0 = rd_cnt; wr0 = wr_cnt; zw0 = zero_wr_cnt; dn0 = done_cnt;
    frame_clear = 1'b1; word_address = 14'd7; bit_offset = 5'd0; word_and_offset_valid = 1'b1;
    @(negedge clk);
    frame_clear = 1'b0; word_and_offset_valid = 1'b0;
    wait_idle("clr timeout", 14000);
    check("clr zero writes", zero_wr_cnt - zw0, DEPTH);
    check("clr total writes", wr_cnt - wr0, DEPTH + 1);
    check("clr reads", rd_cnt - rd0, 1);
    check("clr done pulses", done_cnt - dn0, 1);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ((i == 7) ? 32'h1 : 32'h0)) bad++;
    check("clr frame contents", bad, 0);
    check("clr word7", mem[7], 32'h00000001);

    // Reset aborts a clear at address 100; a new clear restarts from 0.
    do_reset();
    fill(0, 99, 32'hFFFFFFFF, 1'b0);
    fill(100, DEPTH-1, 32'h0, 1'b1);
    frame_clear = 1'b1; @(negedge clk); frame_clear = 1'b0;
    for (int n = 0; n < 200 && !(mem_wr_en && mem_addr == 14'd99); n++) @(negedge clk);
    check("abort reached 99", {18'b0, mem_addr}, 32'd99);
    reset = 1'b1;
    @(negedge clk);
    check("abort wr_en", {31'b0, mem_wr_en}, 32'h0);
    check("abort rd_en", {31'b0, mem_rd_en}, 32'h0);
    check("abort busy", {31'b0, busy}, 32'h0);
    check("abort done", {31'b0, clear_done}, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    check("abort word99", mem[99], 32'h0);
    check("abort word100", mem[100], pat(100));
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ((i < 100) ? 32'h0 : pat(i))) bad++;
    check("abort contents", bad, 0);
    frame_clear = 1'b1; @(negedge clk); frame_clear = 1'b0;
    @(negedge clk);
    check("restart wr_en", {31'b0, mem_wr_en}, 32'h1);
    check("restart addr0", {18'b0, mem_addr}, 32'd0);
    @(negedge clk);
    check("restart addr1", {18'b0, mem_addr}, 32'd1);
    do_reset();

    // Saturation of the drop counter.
    rd0 = rd_cnt; wr0 = wr_cnt;
    word_address = 14'd13824; bit_offset = 5'd0; word_and_offset_valid = 1'b1;
    repeat (70000) @(negedge clk);
    word_and_offset_valid = 1'b0;
    @(negedge clk);
    check("sat dropped", {16'b0, dropped_count}, DROP_EN ? 32'h0000FFFF : 32'h0);
    check("sat accesses", (rd_cnt - rd0) + (wr_cnt - wr0), 0);
    check("rd/wr overlap", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/waveform_bitmap_writer.md
WAVEFORM_BITMAP_WRITER -- requirements
Module: waveform_bitmap_writer

Interface
REQ-001 Parameter DATA_WIDTH, 32, bitmap memory word width; also the number of pixels per word.
REQ-002 Parameter ADDRESS_LENGTH, 14, bitmap memory word-address width.
REQ-003 Parameter DEPTH, 13824, number of valid bitmap words (576 rows x 24 words).
REQ-004 clk  in  1  sole clock, all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 word_address  in  ADDRESS_LENGTH  target word of the pixel to set.
REQ-007 bit_offset  in  5  bit within the target word.
REQ-008 word_and_offset_valid  in  1  single-cycle strobe qualifying word_address/bit_offset.
REQ-009 frame_clear  in  1  single-cycle request to zero the whole bitmap.
REQ-010 mem_addr  out  ADDRESS_LENGTH  memory word address.
REQ-011 mem_rd_en  out  1  memory read strobe; read data is valid on mem_rdata in the following cycle.
REQ-012 mem_rdata  in  DATA_WIDTH  memory read data.
REQ-013 mem_wr_en  out  1  memory write strobe.
REQ-014 mem_wdata  out  DATA_WIDTH  memory write data.
REQ-015 busy  out  1  high when the state is not IDLE or the plot hold register is occupied.
REQ-016 clear_done  out  1  one-cycle pulse after the last clear write.
REQ-017 dropped_count  out  16  saturating count of discarded plot requests.

Function
REQ-018 Plot hold register: one entry; a strobe is captured when the register is empty.
REQ-019 A strobe arriving while the hold register is full shall be discarded and dropped_count incremented.
REQ-020 A strobe with word_address >= DEPTH shall be discarded and dropped_count incremented.
REQ-021 frame_clear shall set clear_pending; a frame_clear arriving while clear_pending is set or the state is CLEAR shall be ignored.
REQ-022 States: IDLE, READ, WAIT, WRITE, CLEAR.
REQ-023 IDLE: with clear_pending -> CLEAR, clearing clear_pending; else with the hold register full -> READ, moving the entry to work registers and freeing the hold register; else stay in IDLE.
REQ-024 READ: mem_addr = work address, mem_rd_en = 1; -> WAIT.
REQ-025 WAIT: capture mem_rdata; -> WRITE.
REQ-026 WRITE: mem_addr = work address, mem_wdata = captured word OR (1 << work bit_offset), mem_wr_en = 1; -> IDLE.
REQ-027 Latency: for a strobe sampled at edge E0 into an empty hold register with the FSM in IDLE, READ occupies cycle E1-E2 and WRITE occupies cycle E3-E4.
REQ-028 CLEAR: write 0 to addresses 0..DEPTH-1 ascending, one per cycle, mem_wr_en = 1; after address DEPTH-1 -> IDLE and pulse clear_done for one cycle.
REQ-029 A simultaneous strobe and frame_clear shall both be latched; the clear is serviced first, and the plot is then written into the cleared frame.
REQ-030 mem_rd_en and mem_wr_en shall never be high in the same cycle; both are 0 in IDLE.
REQ-031 dropped_count shall saturate at 16'hFFFF.

Reset
REQ-032 On reset: state IDLE, hold register empty, clear_pending 0, clear address 0, and mem_rd_en, mem_wr_en, clear_done and dropped_count all 0.
REQ-033 mem_addr and mem_wdata shall reset to 0.
REQ-034 Reset during CLEAR or a read-modify-write shall abort the operation; memory contents are not altered by reset.

Configuration
REQ-035 Macro WAVEFORM_DROP_COUNT_EN defined: dropped_count behaves per REQ-019/020/031.
REQ-036 Macro WAVEFORM_DROP_COUNT_EN undefined: no counter logic; dropped_count is tied to 0; discard behaviour is unchanged.

Verification
REQ-037 Memory word 5 = 0x00000001; strobe addr 5, offset 31 -> one read of 5, then write 0x80000001 to 5 exactly 3 cycles after accept.
REQ-038 Three strobes on consecutive cycles (addr 1/2/3) while IDLE -> addr 1 and 2 are plotted, addr 3 is discarded, dropped_count = 1.
REQ-039 Strobe with addr 13824 -> no memory access, dropped_count = 1.
REQ-040 Simultaneous frame_clear and strobe (addr 7, offset 0) -> 13824 zero writes, one clear_done pulse, then word 7 = 0x00000001.
REQ-041 Assert reset at clear address 100 -> strobes drop to 0 next cycle; words 100..13823 are untouched; a new frame_clear restarts at address 0.
REQ-042 With WAVEFORM_DROP_COUNT_EN defined, 70000 overflowing strobes -> dropped_count = 0xFFFF; with the macro undefined -> dropped_count = 0.
